conv_mem_host: RTL and testbench

Host-side responder for the CONV accelerator interface. It owns the grayscale image memory and the five layer-result banks. It drives the `ready`/`busy` start handshake and serves `iaddr`/`idata` image reads, `cwr` layer writes and `crd` layer reads. After a run it exposes all memories through a load/dump port, so the bench or system side can preload the image and read back results without touching the CONV-facing ports.

---
 rtl/conv_mem_host.sv | 173 +++++++++++++++++
 tb/tb_conv_mem_host.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mem_host.sv
`default_nettype none
// conv_mem_host: host-side responder for the CONV accelerator (start handshake,
// image/layer memories, load/dump port). Rev 1.0
module conv_mem_host #(
   parameter int DATA_WIDTH = 20,
   parameter int TIMEOUT    = 200000
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  ready,
   input  logic                  busy,
   input  logic [11:0]           iaddr,
   output logic [DATA_WIDTH-1:0] idata,
   input  logic                  cwr,
   input  logic [11:0]           caddr_wr,
   input  logic [DATA_WIDTH-1:0] cdata_wr,
   input  logic                  crd,
   input  logic [11:0]           caddr_rd,
   output logic [DATA_WIDTH-1:0] cdata_rd,
   input  logic [2:0]            csel,
   input  logic                  start,
   input  logic                  ld_we,
   input  logic [11:0]           ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_data,
   input  logic [2:0]            dump_sel,
   input  logic [11:0]           dump_addr,
   output logic [DATA_WIDTH-1:0] dump_data,
   output logic                  done,
   output logic                  timeout,
   output logic [2:0]            err,
   output logic [17:0]           run_cycles
);
   localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT);
   localparam logic [31:0] RUN_SAT     = 32'h0003_FFFF;

   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

   state_t                state, state_nx;
   logic [31:0]           run_cnt;
   logic                  timeout_hit;
   logic                  launch;
   logic                  load_blocked;
   logic                  sel_legal;
   logic                  bank_wr;
   logic                  sel_err;
   logic                  range_err;
   logic [DATA_WIDTH-1:0] dump_word;

   logic [DATA_WIDTH-1:0] img_mem  [4096];
   logic [DATA_WIDTH-1:0] l0k0_mem [4096];
   logic [DATA_WIDTH-1:0] l0k1_mem [4096];
   logic [DATA_WIDTH-1:0] l1k0_mem [1024];
   logic [DATA_WIDTH-1:0] l1k1_mem [1024];
   logic [DATA_WIDTH-1:0] l2_mem   [2048];

   // True when sel names a bank and addr lies inside that bank's depth.
   function automatic logic bank_hit(input logic [2:0] sel, input logic [11:0] addr);
      case (sel)
         3'd1, 3'd2: bank_hit = 1'b1;
         3'd3, 3'd4: bank_hit = (addr < 12'd1024);
         3'd5:       bank_hit = (addr < 12'd2048);
         default:    bank_hit = 1'b0;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      timeout_hit = 1'b0;
      case (state)
         IDLE: if (start) state_nx = ARM;
         ARM:  if (busy)  state_nx = RUN;
         RUN: begin
            if (!busy) begin
               state_nx = DONE;
            end else if (run_cnt + 32'd1 >= TIMEOUT_LIM) begin
               state_nx    = DONE;
               timeout_hit = 1'b1;
            end
         end
         DONE: if (start) state_nx = ARM;
         default: state_nx = IDLE;
      endcase
   end

   assign ready        = (state == ARM);
   assign done         = (state == DONE);
   assign launch       = start && ((state == IDLE) || (state == DONE));
   assign load_blocked = (state == ARM) || (state == RUN);

   // The exit edge of RUN is counted too, so a one-cycle busy pulse reports 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_cnt <= '0;
         timeout <= 1'b0;
      end else if (launch) begin
         run_cnt <= '0;
         timeout <= 1'b0;
      end else if (state == RUN) begin
         run_cnt <= run_cnt + 32'd1;
         if (timeout_hit) timeout <= 1'b1;
      end
   end

   assign run_cycles = (run_cnt > RUN_SAT) ? RUN_SAT[17:0] : run_cnt[17:0];

   assign sel_legal = (csel != 3'd0) && (csel < 3'd6);
   assign bank_wr   = cwr && bank_hit(csel, caddr_wr);
   assign sel_err   = (cwr || crd) && !sel_legal;
   assign range_err = sel_legal && ((cwr && !bank_hit(csel, caddr_wr)) ||
                                    (crd && !bank_hit(csel, caddr_rd)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err <= 3'b000;
      else        err <= err | {ld_we && load_blocked, range_err, sel_err};
   end

   always_ff @(posedge clk) begin
      if (ld_we && !load_blocked) img_mem[ld_addr] <= ld_data;
      if (bank_wr) begin
         case (csel)
            3'd1:    l0k0_mem[caddr_wr]       <= cdata_wr;
            3'd2:    l0k1_mem[caddr_wr]       <= cdata_wr;
            3'd3:    l1k0_mem[caddr_wr[9:0]]  <= cdata_wr;
            3'd4:    l1k1_mem[caddr_wr[9:0]]  <= cdata_wr;
            3'd5:    l2_mem[caddr_wr[10:0]]   <= cdata_wr;
            default: ;
         endcase
      end
   end

   assign idata = img_mem[iaddr];

   always_comb begin
      cdata_rd = '0;
      if (crd && bank_hit(csel, caddr_rd)) begin
         case (csel)
            3'd1:    cdata_rd = l0k0_mem[caddr_rd];
            3'd2:    cdata_rd = l0k1_mem[caddr_rd];
            3'd3:    cdata_rd = l1k0_mem[caddr_rd[9:0]];
            3'd4:    cdata_rd = l1k1_mem[caddr_rd[9:0]];
            3'd5:    cdata_rd = l2_mem[caddr_rd[10:0]];
            default: cdata_rd = '0;
         endcase
      end
   end

   always_comb begin
      dump_word = '0;
      if (dump_sel == 3'd0) begin
         dump_word = img_mem[dump_addr];
      end else if (bank_hit(dump_sel, dump_addr)) begin
         case (dump_sel)
            3'd1:    dump_word = l0k0_mem[dump_addr];
            3'd2:    dump_word = l0k1_mem[dump_addr];
            3'd3:    dump_word = l1k0_mem[dump_addr[9:0]];
            3'd4:    dump_word = l1k1_mem[dump_addr[9:0]];
            3'd5:    dump_word = l2_mem[dump_addr[10:0]];
            default: dump_word = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) dump_data <= '0;
      else        dump_data <= dump_word;
   end
endmodule
`default_nettype wire

// File: tb/tb_conv_mem_host.sv
`default_nettype none
// tb_conv_mem_host: randomized scoreboard bench for conv_mem_host. Rev 1.0
module tb_conv_mem_host;
   localparam int DW = 20;
   localparam int K_IDATA = 0, K_CDATA = 1, K_DUMP = 2, K_READY = 3, K_DONE = 4,
                  K_TOUT = 5, K_ERR = 6, K_RUNC = 7, K_TREADY = 8, K_TDONE = 9,
                  K_TTOUT = 10, K_TRUNC = 11, K_TMISC = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          ready, busy, cwr, crd, start, ld_we, done, timeout;
   logic [11:0]   iaddr, caddr_wr, caddr_rd, ld_addr, dump_addr;
   logic [DW-1:0] idata, cdata_wr, cdata_rd, ld_data, dump_data;
   logic [2:0]    csel, dump_sel, err;
   logic [17:0]   run_cycles;

   logic          t_ready, t_busy, t_start, t_done, t_timeout;
   logic [DW-1:0] t_idata, t_cdata_rd, t_dump_data;
   logic [2:0]    t_err;
   logic [17:0]   t_run_cycles;
   logic          zero1  = 1'b0;
   logic [2:0]    zero3  = 3'd0;
   logic [2:0]    t_dsel = 3'd3;
   logic [11:0]   zero12 = 12'd0;
   logic [11:0]   t_dadr = 12'd2000;
   logic [DW-1:0] zerod  = '0;

   always #5 clk = ~clk;

   conv_mem_host dut (
      .clk(clk), .reset(reset), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
      .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd), .caddr_rd(caddr_rd),
      .cdata_rd(cdata_rd), .csel(csel), .start(start), .ld_we(ld_we), .ld_addr(ld_addr),
      .ld_data(ld_data), .dump_sel(dump_sel), .dump_addr(dump_addr), .dump_data(dump_data),
      .done(done), .timeout(timeout), .err(err), .run_cycles(run_cycles));

   conv_mem_host #(.DATA_WIDTH(DW), .TIMEOUT(50)) dut_to (
      .clk(clk), .reset(reset), .ready(t_ready), .busy(t_busy), .iaddr(zero12), .idata(t_idata),
      .cwr(zero1), .caddr_wr(zero12), .cdata_wr(zerod), .crd(zero1), .caddr_rd(zero12),
      .cdata_rd(t_cdata_rd), .csel(zero3), .start(t_start), .ld_we(zero1), .ld_addr(zero12),
      .ld_data(zerod), .dump_sel(t_dsel), .dump_addr(t_dadr), .dump_data(t_dump_data),
      .done(t_done), .timeout(t_timeout), .err(t_err), .run_cycles(t_run_cycles));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int cyc; int kind; logic [31:0] exp; } chk_t;
   chk_t sb[$];
   int total = 0, bad = 0;

   // Reference model: memories as sparse maps, error flags, and run phase.
   logic [DW-1:0] img_m  [int];
   logic [DW-1:0] bank_m [int];
   int            img_keys[$];
   int            bank_keys[$];
   logic [2:0]    err_m = 3'b000;
   bit            running = 1'b0;

   function automatic int depth(input logic [2:0] s);
      case (s)
         3'd1, 3'd2: return 4096;
         3'd3, 3'd4: return 1024;
         3'd5:       return 2048;
         default:    return 0;
      endcase
   endfunction

   function automatic void push_chk(input int kind, input logic [31:0] v, input int dly);
      chk_t c;
      c.cyc = cyc + dly; c.kind = kind; c.exp = v;
      sb.push_back(c);
   endfunction

   task automatic check_item(input chk_t c);
      logic [31:0] act;
      string       nm;
      act = '0; nm = "unknown";
      case (c.kind)
         K_IDATA:  begin act = 32'(idata);        nm = "idata";       end
         K_CDATA:  begin act = 32'(cdata_rd);     nm = "cdata_rd";    end
         K_DUMP:   begin act = 32'(dump_data);    nm = "dump_data";   end
         K_READY:  begin act = 32'(ready);        nm = "ready";       end
         K_DONE:   begin act = 32'(done);         nm = "done";        end
         K_TOUT:   begin act = 32'(timeout);      nm = "timeout";     end
         K_ERR:    begin act = 32'(err);          nm = "err";         end
         K_RUNC:   begin act = 32'(run_cycles);   nm = "run_cycles";  end
         K_TREADY: begin act = 32'(t_ready);      nm = "to_ready";    end
         K_TDONE:  begin act = 32'(t_done);       nm = "to_done";     end
         K_TTOUT:  begin act = 32'(t_timeout);    nm = "to_timeout";  end
         K_TRUNC:  begin act = 32'(t_run_cycles); nm = "to_run_cycles"; end
         K_TMISC:  begin act = {9'd0, t_err, t_cdata_rd}; nm = "to_err_rd"; end
         default:  ;
      endcase
      total++;
      if (act !== c.exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, c.exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      int i;
      i = 0;
      while (i < sb.size()) begin
         if (sb[i].cyc <= cyc) begin
            check_item(sb[i]);
            sb.delete(i);
         end else begin
            i++;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
      cwr = 1'b0; crd = 1'b0; ld_we = 1'b0; start = 1'b0; t_start = 1'b0;
   endtask

   function automatic logic [11:0] pick_addr(input logic [2:0] s);
      int d;
      d = depth(s);
      if (d == 0) return 12'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
         0:       return 12'd0;
         1:       return 12'(d - 1);
         2:       return (d < 4096) ? 12'(d) : 12'(d - 1);
         default: return 12'($urandom_range(0, d - 1));
      endcase
   endfunction

   task automatic model_bank_write(input logic [2:0] s, input logic [11:0] a, input logic [DW-1:0] d);
      int key;
      if (depth(s) == 0) err_m[0] = 1'b1;
      else if (int'(a) >= depth(s)) err_m[1] = 1'b1;
      else begin
         key = int'(s) * 4096 + int'(a);
         if (!bank_m.exists(key)) bank_keys.push_back(key);
         bank_m[key] = d;
      end
   endtask

   // One cycle of random traffic; advances the clock.
   task automatic rand_op();
      logic [2:0]    s;
      logic [11:0]   a;
      logic [DW-1:0] d;
      int            key;
      push_chk(K_ERR, 32'(err_m), 0);
      case ($urandom_range(0, 4))
         0: begin
            a = 12'($urandom_range(0, 4095)); d = DW'($urandom);
            ld_we = 1'b1; ld_addr = a; ld_data = d;
            if (running) err_m[2] = 1'b1;
            else begin
               if (!img_m.exists(int'(a))) img_keys.push_back(int'(a));
               img_m[int'(a)] = d;
            end
         end
         1: begin
            s = 3'($urandom_range(0, 7)); a = pick_addr(s); d = DW'($urandom);
            cwr = 1'b1; csel = s; caddr_wr = a; cdata_wr = d;
            model_bank_write(s, a, d);
         end
         2: begin
            if (bank_keys.size() > 0 && $urandom_range(0, 3) != 0) begin
               key = bank_keys[$urandom_range(0, bank_keys.size() - 1)];
               s = 3'(key / 4096); a = 12'(key % 4096);
               push_chk(K_CDATA, 32'(bank_m[key]), 0);
            end else if ($urandom_range(0, 1) == 1) begin
               s = 3'($urandom_range(5, 7)); if (s == 3'd5) s = 3'd0;
               a = 12'($urandom_range(0, 4095)); err_m[0] = 1'b1;
               push_chk(K_CDATA, 32'd0, 0);
            end else begin
               s = 3'($urandom_range(3, 5));
               a = 12'($urandom_range(depth(s), 4095)); err_m[1] = 1'b1;
               push_chk(K_CDATA, 32'd0, 0);
            end
            crd = 1'b1; csel = s; caddr_rd = a;
         end
         3: begin
            if (img_keys.size() > 0) begin
               key = img_keys[$urandom_range(0, img_keys.size() - 1)];
               iaddr = 12'(key);
               push_chk(K_IDATA, 32'(img_m[key]), 0);
            end
         end
         default: begin
            if ($urandom_range(0, 2) == 0 && img_keys.size() > 0) begin
               key = img_keys[$urandom_range(0, img_keys.size() - 1)];
               dump_sel = 3'd0; dump_addr = 12'(key);
               push_chk(K_DUMP, 32'(img_m[key]), 1);
            end else if (bank_keys.size() > 0 && $urandom_range(0, 1) == 0) begin
               key = bank_keys[$urandom_range(0, bank_keys.size() - 1)];
               dump_sel = 3'(key / 4096); dump_addr = 12'(key % 4096);
               push_chk(K_DUMP, 32'(bank_m[key]), 1);
            end else begin
               dump_sel = 3'($urandom_range(6, 7)); dump_addr = 12'($urandom_range(0, 4095));
               push_chk(K_DUMP, 32'd0, 1);
            end
         end
      endcase
      tick();
   endtask

   initial begin
      reset = 1'b0; busy = 1'b0; cwr = 1'b0; crd = 1'b0; start = 1'b0; ld_we = 1'b0;
      iaddr = '0; caddr_wr = '0; caddr_rd = '0; ld_addr = '0; dump_addr = '0;
      cdata_wr = '0; ld_data = '0; csel = '0; dump_sel = '0; t_busy = 1'b0; t_start = 1'b0;
      tick(); tick();
      push_chk(K_READY, 0, 0); push_chk(K_DONE, 0, 0); push_chk(K_TOUT, 0, 0);
      push_chk(K_ERR, 0, 0); push_chk(K_RUNC, 0, 0); push_chk(K_DUMP, 0, 0);
      push_chk(K_TREADY, 0, 0);
      tick();
      reset = 1'b1;
      tick();

      // Directed image preload and same-cycle readback.
      ld_we = 1'b1; ld_addr = 12'd100; ld_data = 20'h0A5C3;
      img_m[100] = 20'h0A5C3; img_keys.push_back(100);
      tick();
      iaddr = 12'd100; push_chk(K_IDATA, 32'h0A5C3, 0);
      tick();

      // L1 K0 boundary: last legal word, first illegal word, write/read collision.
      cwr = 1'b1; csel = 3'd3; caddr_wr = 12'd1023; cdata_wr = 20'h12345;
      model_bank_write(3'd3, 12'd1023, 20'h12345);
      tick();
      crd = 1'b1; csel = 3'd3; caddr_rd = 12'd1023; push_chk(K_CDATA, 32'h12345, 0);
      tick();
      cwr = 1'b1; csel = 3'd3; caddr_wr = 12'd1024; cdata_wr = 20'h54321;
      model_bank_write(3'd3, 12'd1024, 20'h54321);
      tick();
      push_chk(K_ERR, 32'(err_m), 0);
      crd = 1'b1; csel = 3'd3; caddr_rd = 12'd1024; push_chk(K_CDATA, 32'd0, 0);
      tick();
      cwr = 1'b1; crd = 1'b1; csel = 3'd3; caddr_wr = 12'd1023; caddr_rd = 12'd1023;
      cdata_wr = 20'h0BEEF; push_chk(K_CDATA, 32'h12345, 0);
      model_bank_write(3'd3, 12'd1023, 20'h0BEEF);
      tick();
      crd = 1'b1; csel = 3'd3; caddr_rd = 12'd1023; push_chk(K_CDATA, 32'h0BEEF, 0);
      tick();

      repeat (60) rand_op();

      // Run 1: busy low for 5 ARM cycles, then high for exactly 300 cycles.
      start = 1'b1; push_chk(K_READY, 0, 0);
      tick();
      running = 1'b1;
      for (int k = 0; k < 5; k++) begin
         busy = 1'b0; push_chk(K_READY, 1, 0); push_chk(K_DONE, 0, 0);
         rand_op();
      end
      for (int k = 0; k < 300; k++) begin
         busy = 1'b1;
         push_chk(K_READY, (k == 0) ? 32'd1 : 32'd0, 0);
         if (k == 20) start = 1'b1;
         if (k == 40) begin
            ld_we = 1'b1; ld_addr = 12'd100; ld_data = 20'h11111;
            err_m[2] = 1'b1;
            tick();
         end else begin
            rand_op();
         end
      end
      busy = 1'b0; push_chk(K_READY, 0, 0); push_chk(K_DONE, 0, 0);
      rand_op();
      running = 1'b0;
      push_chk(K_DONE, 1, 0); push_chk(K_RUNC, 300, 0); push_chk(K_TOUT, 0, 0);
      push_chk(K_READY, 0, 0); push_chk(K_ERR, 32'(err_m), 0);
      iaddr = 12'd100; push_chk(K_IDATA, 32'(img_m[100]), 0);
      tick();
      repeat (20) rand_op();

      // Run 2 from DONE: one-cycle busy pulse still gives a one-cycle run.
      start = 1'b1;
      tick();
      running = 1'b1;
      busy = 1'b1;
      push_chk(K_DONE, 0, 0); push_chk(K_RUNC, 0, 0); push_chk(K_READY, 1, 0);
      push_chk(K_TOUT, 0, 0);
      tick();
      busy = 1'b0; push_chk(K_READY, 0, 0); push_chk(K_DONE, 0, 0);
      tick();
      running = 1'b0;
      push_chk(K_DONE, 1, 0); push_chk(K_RUNC, 1, 0);
      tick();

      // L2 top word via dump port, then an illegal-select write must not alter it.
      cwr = 1'b1; csel = 3'd5; caddr_wr = 12'd2047; cdata_wr = 20'hFFFFF;
      model_bank_write(3'd5, 12'd2047, 20'hFFFFF);
      tick();
      dump_sel = 3'd5; dump_addr = 12'd2047; push_chk(K_DUMP, 32'hFFFFF, 1);
      tick();
      cwr = 1'b1; csel = 3'd7; caddr_wr = 12'd2047; cdata_wr = 20'h00000;
      model_bank_write(3'd7, 12'd2047, 20'h00000);
      tick();
      push_chk(K_ERR, 32'(err_m), 0);
      crd = 1'b1; csel = 3'd5; caddr_rd = 12'd2047; push_chk(K_CDATA, 32'hFFFFF, 0);
      push_chk(K_DUMP, 32'hFFFFF, 1);
      tick();
      repeat (40) rand_op();

      // Timeout instance (TIMEOUT=50) with busy stuck high.
      t_start = 1'b1; push_chk(K_TREADY, 0, 0);
      tick();
      t_busy = 1'b1; push_chk(K_TREADY, 1, 0);
      tick();
      for (int k = 0; k < 50; k++) begin
         push_chk(K_TREADY, 0, 0); push_chk(K_TDONE, 0, 0);
         tick();
      end
      push_chk(K_TDONE, 1, 0); push_chk(K_TTOUT, 1, 0); push_chk(K_TRUNC, 50, 0);
      push_chk(K_TMISC, 32'd0, 0);
      tick();
      repeat (4) tick();

      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
